// File: rtl/dcache_2way_top_if.sv
// -----------------------------------------------------------------------------
// dcache_2way_top_if
// Bus bundle for the two-way data cache: the CPU data port (p1_*) and the
// line-wide data-memory port (mem_*). Signal names keep the cache-centric
// _i/_o suffixes so the cache side reads like its original port list.
//
// Modports:
//   slave  - the cache: consumes CPU requests and memory responses,
//            produces load data, stall and memory requests.
//   master - the environment (CPU + memory) driving the cache.
// -----------------------------------------------------------------------------
interface dcache_2way_top_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  // memory side
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  // CPU side
  logic [31:0]       p1_data_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;

  modport slave (
    input  mem_data_i, mem_ack_i,
    output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
    input  p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
    output p1_data_o, p1_stall_o
  );

  modport master (
    output mem_data_i, mem_ack_i,
    input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
    output p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i,
    input  p1_data_o, p1_stall_o
  );
endinterface

// File: rtl/dcache_2way_top.sv
// -----------------------------------------------------------------------------
// dcache_2way_top
// Two-way set-associative, write-back, write-allocate data cache between the
// CPU data port and the line-wide data memory. Tag/valid/dirty/LRU/data are
// register arrays with combinational read, so hits complete without stall.
// Victim choice: first invalid way (way0 first), otherwise the LRU way.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous reset, active high
//   bus    - dcache_2way_top_if.slave (CPU p1_* port and memory mem_* port)
//   hit_cnt_o / miss_cnt_o / wb_cnt_o (32b) - present only when the
//            DCACHE_PERF_CNT_EN macro is defined; wrap-around event counters.
// -----------------------------------------------------------------------------
module dcache_2way_top #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dcache_2way_top_if.slave bus
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]      hit_cnt_o,
  output logic [31:0]      miss_cnt_o,
  output logic [31:0]      wb_cnt_o
`endif
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_MISS        = 3'd1,
    S_WRITEBACK   = 3'd2,
    S_REFILL      = 3'd3,
    S_REFILL_DONE = 3'd4
  } state_t;

  // storage
  logic [TAG_W-1:0]  tag_r   [SETS][2];
  logic [LINE_W-1:0] data_r  [SETS][2];
  logic [1:0]        valid_r [SETS];
  logic [1:0]        dirty_r [SETS];
  logic [SETS-1:0]   lru_r;            // per set: index of the way to evict next

  // FSM and latched miss context
  state_t            state_r, state_s;
  logic [IDX_W-1:0]  idx_lat_r;
  logic [TAG_W-1:0]  tag_lat_r;
  logic              victim_r;

  // registered memory port
  logic              mem_enable_r, mem_enable_s;
  logic              mem_write_r,  mem_write_s;
  logic [ADDR_W-1:0] mem_addr_r,   mem_addr_s;
  logic [LINE_W-1:0] mem_data_r,   mem_data_s;

  // decode and control
  logic [TAG_W-1:0]  tag_s;
  logic [IDX_W-1:0]  idx_s;
  logic [WSEL_W-1:0] wsel_s;
  logic              unused_byte_s;
  logic              req_s;
  logic [1:0]        way_hit_s;
  logic              hit_s;
  logic              hit_way_s;
  logic              wr_hit_s;
  logic              victim_s;
  logic              latch_s;
  logic              wb_done_s;
  logic              fill_s;
  logic [ADDR_W-1:0] wb_addr_s;
  logic [ADDR_W-1:0] fill_addr_s;

  assign tag_s         = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign idx_s         = bus.p1_addr_i[OFF_W +: IDX_W];
  assign wsel_s        = bus.p1_addr_i[2 +: WSEL_W];
  // Byte-within-word bits carry no meaning for a word-granular cache.
  assign unused_byte_s = ^bus.p1_addr_i[1:0];

  assign req_s        = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign way_hit_s[0] = valid_r[idx_s][0] && (tag_r[idx_s][0] == tag_s);
  assign way_hit_s[1] = valid_r[idx_s][1] && (tag_r[idx_s][1] == tag_s);
  // Exactly one matching way counts as a hit; a store wins over a load.
  assign hit_s        = req_s && (state_r == S_IDLE) && (way_hit_s[0] ^ way_hit_s[1]);
  assign hit_way_s    = way_hit_s[1];
  assign wr_hit_s     = hit_s && bus.p1_MemWrite_i;

  assign bus.p1_stall_o = req_s && !hit_s;
  assign bus.p1_data_o  = data_r[idx_s][hit_way_s][{wsel_s, 5'd0} +: 32];

  assign wb_addr_s   = {tag_r[idx_lat_r][victim_r], idx_lat_r, {OFF_W{1'b0}}};
  assign fill_addr_s = {tag_lat_r, idx_lat_r, {OFF_W{1'b0}}};

  assign bus.mem_enable_o = mem_enable_r;
  assign bus.mem_write_o  = mem_write_r;
  assign bus.mem_addr_o   = mem_addr_r;
  assign bus.mem_data_o   = mem_data_r;

  // Victim selection for the current request: invalid ways first, then LRU.
  always_comb begin
    victim_s = lru_r[idx_s];
    if (!valid_r[idx_s][0]) begin
      victim_s = 1'b0;
    end else if (!valid_r[idx_s][1]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_r[idx_s];
    end
  end

  // Next-state and next memory-port values; port values only change on
  // transitions so they stay stable while a request is outstanding.
  always_comb begin
    state_s      = state_r;
    mem_enable_s = mem_enable_r;
    mem_write_s  = mem_write_r;
    mem_addr_s   = mem_addr_r;
    mem_data_s   = mem_data_r;
    latch_s      = 1'b0;
    wb_done_s    = 1'b0;
    fill_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req_s && !hit_s) begin
          state_s = S_MISS;
          latch_s = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_MISS: begin
        mem_enable_s = 1'b1;
        if (valid_r[idx_lat_r][victim_r] && dirty_r[idx_lat_r][victim_r]) begin
          state_s     = S_WRITEBACK;
          mem_write_s = 1'b1;
          mem_addr_s  = wb_addr_s;
          mem_data_s  = data_r[idx_lat_r][victim_r];
        end else begin
          state_s     = S_REFILL;
          mem_write_s = 1'b0;
          mem_addr_s  = fill_addr_s;
        end
      end
      S_WRITEBACK: begin
        if (bus.mem_ack_i) begin
          state_s     = S_REFILL;
          wb_done_s   = 1'b1;
          mem_write_s = 1'b0;
          mem_addr_s  = fill_addr_s;
        end else begin
          state_s = S_WRITEBACK;
        end
      end
      S_REFILL: begin
        if (bus.mem_ack_i) begin
          state_s      = S_REFILL_DONE;
          fill_s       = 1'b1;
          mem_enable_s = 1'b0;
        end else begin
          state_s = S_REFILL;
        end
      end
      S_REFILL_DONE: begin
        state_s      = S_IDLE;
        mem_enable_s = 1'b0;
      end
      default: begin
        state_s      = S_IDLE;
        mem_enable_s = 1'b0;
        mem_write_s  = 1'b0;
      end
    endcase
  end

  // FSM state, latched miss context and registered memory port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= S_IDLE;
      mem_enable_r <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_data_r   <= {LINE_W{1'b0}};
      idx_lat_r    <= {IDX_W{1'b0}};
      tag_lat_r    <= {TAG_W{1'b0}};
      victim_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      mem_enable_r <= mem_enable_s;
      mem_write_r  <= mem_write_s;
      mem_addr_r   <= mem_addr_s;
      mem_data_r   <= mem_data_s;
      if (latch_s) begin
        idx_lat_r <= idx_s;
        tag_lat_r <= tag_s;
        victim_r  <= victim_s;
      end
    end
  end

  // Valid/dirty/LRU bookkeeping; cleared by reset so every line is invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SETS; i++) begin
        valid_r[i] <= 2'b00;
        dirty_r[i] <= 2'b00;
      end
      lru_r <= {SETS{1'b0}};
    end else begin
      if (hit_s) begin
        lru_r[idx_s] <= ~hit_way_s;
      end
      if (wr_hit_s) begin
        dirty_r[idx_s][hit_way_s] <= 1'b1;
      end
      if (wb_done_s) begin
        dirty_r[idx_lat_r][victim_r] <= 1'b0;
      end
      if (fill_s) begin
        valid_r[idx_lat_r][victim_r] <= 1'b1;
        dirty_r[idx_lat_r][victim_r] <= 1'b0;
      end
    end
  end

  // Tag and data arrays: no reset, contents are qualified by valid.
  always_ff @(posedge clk_i) begin
    if (fill_s) begin
      data_r[idx_lat_r][victim_r] <= bus.mem_data_i;
      tag_r[idx_lat_r][victim_r]  <= tag_lat_r;
    end
    if (wr_hit_s) begin
      data_r[idx_s][hit_way_s][{wsel_s, 5'd0} +: 32] <= bus.p1_data_i;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // Event counters: hits, IDLE->MISS entries, MISS->WRITEBACK entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
      wb_cnt_o   <= 32'd0;
    end else begin
      if (hit_s) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (latch_s) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
      if ((state_r == S_MISS) && (state_s == S_WRITEBACK)) begin
        wb_cnt_o <= wb_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/dcache_2way_top.md
Name: dcache_2way_top

Overview:
Two-way set-associative, write-back, write-allocate data cache placed between the CPU data port and the 256-bit-class data memory. It generalises the direct-mapped data cache with parametrised line width and set count, true-LRU replacement per set, and victim selection that prefers invalid ways. Tag, valid, dirty, LRU and data storage are internal register arrays with combinational read, so a hit completes with no stall.

Parameters:
ADDR_W, 32, CPU byte-address width.
LINE_W, 256, line width in bits; power of two, at least 64.
SETS, 32, number of sets; power of two, at least 2.
Derived: OFF_W = log2(LINE_W/8), IDX_W = log2(SETS), TAG_W = ADDR_W-IDX_W-OFF_W.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
mem_data_i  in  LINE_W  refill line from memory
mem_ack_i  in  1  memory done, single-cycle pulse
mem_data_o  out  LINE_W  write-back line
mem_addr_o  out  ADDR_W  line-aligned address (offset bits 0)
mem_enable_o  out  1  memory request, held until ack
mem_write_o  out  1  1 = write-back, 0 = refill
p1_data_i  in  32  CPU store data
p1_addr_i  in  ADDR_W  CPU byte address
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request
p1_data_o  out  32  load data
p1_stall_o  out  1  CPU stall

Behaviour:
- Reset (async, rst_i=1): state IDLE; all valid, dirty and LRU bits 0; mem_enable_o=0, mem_write_o=0, mem_addr_o=0. p1_stall_o is low while no request is present. Data array is not cleared.
- Address split: offset [OFF_W-1:0], index [OFF_W+IDX_W-1:OFF_W], tag above. Word select = offset[OFF_W-1:2]; byte bits [1:0] are ignored.
- p1_req = MemRead|MemWrite. If both are high, the access is a write.
- hit = p1_req & state==IDLE & exactly one way where valid & tag match. p1_stall_o = p1_req & ~hit, combinational.
- Read hit: p1_data_o = selected word of the hit way, same cycle. When there is no hit, p1_data_o is don't-care.
- Write hit: at the clock edge, the word is written into the hit way and dirty is set. No memory traffic.
- Any hit (read or write) updates the set's LRU bit to point at the other way.
- States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE.
  - IDLE -> MISS: on p1_req & ~hit. Victim is latched at this point: the first invalid way (way0 has priority); otherwise the way named by LRU.
  - MISS -> WRITEBACK if the victim is valid & dirty. Drive mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 0}, mem_data_o = victim line.
  - MISS -> REFILL otherwise. Drive mem_enable_o=1, mem_write_o=0, mem_addr_o={p1 tag, index, 0}.
  - WRITEBACK: stay until mem_ack_i. On ack, clear the victim's dirty bit and go to REFILL with mem_write_o=0 and the refill address.
  - REFILL: stay until mem_ack_i. On ack, write mem_data_i into the victim way, set valid=1, dirty=0, tag = p1 tag. Go to REFILL_DONE.
  - REFILL_DONE: mem_enable_o=0. Return to IDLE. The held request then hits in IDLE; a store completes as a write hit in that cycle.
- All memory outputs are registered and stable while mem_enable_o=1.
- mem_ack_i is ignored in IDLE, MISS and REFILL_DONE.
- If p1_req drops or the address changes mid-miss, the in-flight transaction still completes using the latched index, tag and victim. The line is filled and no CPU data is written.
- Reset mid-operation: the FSM aborts immediately, mem_enable_o falls asynchronously, and all lines are invalidated.
- Miss latency, excluding memory wait: one MISS cycle, plus memory cycles, plus one REFILL_DONE cycle, plus the hit cycle.

Optional Feature:
DCACHE_PERF_CNT_EN
- Defined: adds outputs hit_cnt_o[31:0], miss_cnt_o[31:0] and wb_cnt_o[31:0], all reset to 0, all wrap-around.
  - hit_cnt_o increments on every IDLE cycle with a hit.
  - miss_cnt_o increments on every IDLE->MISS transition.
  - wb_cnt_o increments on every MISS->WRITEBACK transition.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Cold read 0x00000000 after reset -> stall, single REFILL, no write-back, mem_addr_o=0x00000000. After ack with line word0=0xDEADBEEF, p1_data_o=0xDEADBEEF in the first IDLE cycle, stall low.
- Read 0x00000400 after the above (same set 0, way0 valid) -> refill goes to way1 (invalid preferred). Re-reading 0x00000000 and 0x00000400 both hit with no memory traffic.
- Write 0x12345678 to 0x00000004 (hit) -> no stall, no memory access. Then read 0x00000004 -> returns 0x12345678.
- LRU and dirty eviction: after the steps above (way0 dirty, last touched; way1 LRU), read 0x00000800 -> way1 evicted clean, no write-back. Then read 0x00000400 -> evicts dirty way0: WRITEBACK to 0x00000000 with word1=0x12345678, then REFILL from 0x00000400.
- Write miss to 0x00000C08 with data 0xA5A5A5A5 -> refill, then write hit in the first IDLE cycle. Line is dirty and a later read returns 0xA5A5A5A5.
- Assert rst_i during WRITEBACK with mem_enable_o=1 -> mem_enable_o=0 within the same cycle, state IDLE. The next access to any address misses.
